// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared opcodes, encodings, control-word indices and field types
//            for the RV32 pipelined control unit.
// Revision : 1.0
// ============================================================================
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;

    localparam int CTRL_W        = 13;
    localparam int CTRL_PCSEL    = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_RSV_HI   = 2;
    localparam int CTRL_RSV_LO   = 3;
    localparam int CTRL_IMM_HI   = 4;
    localparam int CTRL_IMM_LO   = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_ALUOP_HI = 7;
    localparam int CTRL_ALUOP_LO = 10;
    localparam int CTRL_MEMWRITE = 11;
    localparam int CTRL_MEM2REG  = 12;

    // A taken branch discards the word in D now and the one fetched next
    localparam logic [1:0] SQUASH_LEN = 2'd2;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       bne;
        logic       alusrc;
        logic [3:0] aluop;
        logic       regwrite;
        logic       memwrite;
        logic       mem2reg;
        logic [1:0] imm;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       bne;
        logic       alusrc;
        logic [3:0] aluop;
        logic       regwrite;
        logic       memwrite;
        logic       mem2reg;
    } ex_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memwrite;
        logic mem2reg;
    } mw_t;

endpackage
`default_nettype wire

// File: rtl/rv32_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ctrl_pipe_if
// Brief    : Instruction/flag inputs and control-word outputs of the control unit.
// Revision : 1.0
// ============================================================================
interface rv32_ctrl_pipe_if #(
    parameter int XLEN = 32
);
    import rv32_pkg::*;

    logic [31:0]       inst;
    logic              alu_zero;
    logic [0:CTRL_W-1] ctrl;
    logic              illegal;
    logic [XLEN-1:0]   instret;

    modport master (
        output inst,
        output alu_zero,
        input  ctrl,
        input  illegal,
        input  instret
    );

    modport slave (
        input  inst,
        input  alu_zero,
        output ctrl,
        output illegal,
        output instret
    );

endinterface
`default_nettype wire

// File: rtl/rv32_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv32_decode
// Brief    : Combinational opcode/funct decode into control fields plus an
//            illegal-instruction indication; illegal words decode as bubbles.
// Revision : 1.0
// ============================================================================
module rv32_decode
    import rv32_pkg::*;
(
    input  wire logic [6:0] opcode,
    input  wire logic [2:0] funct3,
    input  wire logic       bit30,
    output dec_t            dec,
    output logic            illegal
);

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec.valid    = 1'b1;
                dec.aluop    = {bit30, funct3};
                dec.regwrite = 1'b1;
            end
            OP_IMM: begin
                // Only shifts use bit 30 as an opcode modifier; elsewhere it is immediate data
                dec.valid    = 1'b1;
                dec.aluop    = {bit30 & (funct3 == F3_SR), funct3};
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    dec.valid    = 1'b1;
                    dec.aluop    = ALU_ADD;
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.mem2reg  = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    dec.valid    = 1'b1;
                    dec.imm      = IMM_S;
                    dec.aluop    = ALU_ADD;
                    dec.alusrc   = 1'b1;
                    dec.memwrite = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    dec.valid  = 1'b1;
                    dec.imm    = IMM_B;
                    dec.aluop  = ALU_SUB;
                    dec.branch = 1'b1;
                    dec.bne    = (funct3 == F3_BNE);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ctrl_pipe
// Brief    : Three-stage control pipeline: decode, EX/MW control registers,
//            branch squash, sticky illegal flag and retire counter.
// Revision : 1.0
// ============================================================================
module rv32_ctrl_pipe
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rv32_ctrl_pipe_if.slave   bus
);

    dec_t            w_dec;
    logic            w_dec_illegal;
    logic            w_taken;
    logic [1:0]      w_squash_cnt;
    logic            w_squash;

    ex_t             r_ex;
    mw_t             r_mw;
    logic [1:0]      r_squash_cnt;
    logic            r_illegal;
    logic [XLEN-1:0] r_instret;

    rv32_decode u_decode (
        .opcode  (bus.inst[6:0]),
        .funct3  (bus.inst[14:12]),
        .bit30   (bus.inst[30]),
        .dec     (w_dec),
        .illegal (w_dec_illegal)
    );

    assign w_taken = r_ex.branch & (r_ex.bne ? ~bus.alu_zero : bus.alu_zero);

    // A taken branch opens the window in its own cycle, so the D word alongside it is discarded too
    assign w_squash_cnt = w_taken ? SQUASH_LEN : r_squash_cnt;
    assign w_squash     = (w_squash_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex         <= '0;
            r_mw         <= '0;
            r_squash_cnt <= 2'd0;
            r_illegal    <= 1'b0;
            r_instret    <= '0;
        end else begin
            if (w_squash) begin
                r_ex <= '0;
            end else begin
                r_ex.valid    <= w_dec.valid;
                r_ex.branch   <= w_dec.branch;
                r_ex.bne      <= w_dec.bne;
                r_ex.alusrc   <= w_dec.alusrc;
                r_ex.aluop    <= w_dec.aluop;
                r_ex.regwrite <= w_dec.regwrite;
                r_ex.memwrite <= w_dec.memwrite;
                r_ex.mem2reg  <= w_dec.mem2reg;
            end

            r_mw.valid    <= r_ex.valid;
            r_mw.regwrite <= r_ex.regwrite & ~r_ex.branch;
            r_mw.memwrite <= r_ex.memwrite & ~r_ex.branch;
            r_mw.mem2reg  <= r_ex.mem2reg  & ~r_ex.branch;

            r_squash_cnt <= w_squash ? (w_squash_cnt - 2'd1) : 2'd0;

            if (w_dec_illegal && !w_squash) begin
                r_illegal <= 1'b1;
            end

            if (r_mw.valid) begin
                r_instret <= r_instret + XLEN'(1);
            end
        end
    end

    always_comb begin
        bus.ctrl                                = '0;
        bus.ctrl[CTRL_PCSEL]                    = w_taken;
        bus.ctrl[CTRL_REGWRITE]                 = r_mw.regwrite;
        bus.ctrl[CTRL_IMM_HI:CTRL_IMM_LO]       = w_dec.imm;
        bus.ctrl[CTRL_ALUSRC]                   = r_ex.alusrc;
        bus.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = r_ex.aluop;
        bus.ctrl[CTRL_MEMWRITE]                 = r_mw.memwrite;
        bus.ctrl[CTRL_MEM2REG]                  = r_mw.mem2reg;
    end

    assign bus.illegal = r_illegal;
    assign bus.instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_rv32_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_ctrl_pipe
// Brief    : Directed self-checking bench for rv32_ctrl_pipe.
// Revision : 1.0
// ============================================================================
module tb_rv32_ctrl_pipe;

    localparam int XLEN = 32;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_LW   = 32'h0040A183;
    localparam logic [31:0] I_SRAI = 32'h4030D193;
    localparam logic [31:0] I_ADDI = 32'hC0008193;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rv32_ctrl_pipe_if #(.XLEN(XLEN)) bus ();

    rv32_ctrl_pipe #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // New D word just after the rising edge; checks follow shortly after, away from both edges
    task automatic step(input logic [31:0] word, input logic az);
        @(posedge clk);
        #1;
        bus.inst     = word;
        bus.alu_zero = az;
        #2;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.inst     = I_SW;
        bus.alu_zero = 1'b0;

        step(I_SW, 1'b0);
        step(I_SW, 1'b0);
        check("rst_imm_follows_d", 32'(bus.ctrl[4:5]), 32'h1);
        check("rst_ctrl_0_3",      32'(bus.ctrl[0:3]), 32'h0);
        check("rst_ctrl_6_12",     32'(bus.ctrl[6:12]), 32'h0);
        check("rst_illegal",       32'(bus.illegal), 32'h0);
        check("rst_instret",       bus.instret, 32'h0);

        // Straight-line code: add, sw, sub, lw, srai, addi, add
        step(I_ADD, 1'b0); rst = 1'b0;
        check("c1_r_imm", 32'(bus.ctrl[4:5]), 32'h0);
        step(I_SW, 1'b0);
        check("c2_add_alusrc", 32'(bus.ctrl[6]), 32'h0);
        check("c2_add_aluop",  32'(bus.ctrl[7:10]), 32'h0);
        check("c2_sw_imm",     32'(bus.ctrl[4:5]), 32'h1);
        step(I_SUB, 1'b0);
        check("c3_add_regwrite", 32'(bus.ctrl[1]), 32'h1);
        check("c3_add_mem2reg",  32'(bus.ctrl[12]), 32'h0);
        check("c3_sw_alusrc",    32'(bus.ctrl[6]), 32'h1);
        check("c3_instret",      bus.instret, 32'd0);
        step(I_LW, 1'b0);
        check("c4_instret",      bus.instret, 32'd1);
        check("c4_sw_memwrite",  32'(bus.ctrl[11]), 32'h1);
        check("c4_sw_regwrite",  32'(bus.ctrl[1]), 32'h0);
        check("c4_sub_aluop",    32'(bus.ctrl[7:10]), 32'h8);
        step(I_SRAI, 1'b0);
        check("c5_lw_alusrc",    32'(bus.ctrl[6]), 32'h1);
        check("c5_lw_aluop",     32'(bus.ctrl[7:10]), 32'h0);
        step(I_ADDI, 1'b0);
        check("c6_lw_mem2reg",   32'(bus.ctrl[12]), 32'h1);
        check("c6_lw_regwrite",  32'(bus.ctrl[1]), 32'h1);
        check("c6_srai_aluop",   32'(bus.ctrl[7:10]), 32'hD);
        step(I_ADD, 1'b0);
        check("c7_addi_aluop",   32'(bus.ctrl[7:10]), 32'h0);
        check("c7_instret",      bus.instret, 32'd4);

        // Taken beq: the two following words are squashed
        step(I_BEQ, 1'b0);
        check("c8_b_imm",        32'(bus.ctrl[4:5]), 32'h2);
        step(I_ADD, 1'b1);
        check("c9_beq_taken",    32'(bus.ctrl[0]), 32'h1);
        check("c9_beq_aluop",    32'(bus.ctrl[7:10]), 32'h8);
        check("c9_instret",      bus.instret, 32'd6);
        step(I_ADD, 1'b0);
        check("c10_branch_nowrite", 32'(bus.ctrl[1]), 32'h0);
        check("c10_ex_bubble_pc",   32'(bus.ctrl[0]), 32'h0);
        step(I_ADD, 1'b1);
        check("c11_squash_write", 32'(bus.ctrl[1]), 32'h0);
        check("c11_squash_pc",    32'(bus.ctrl[0]), 32'h0);
        check("c11_instret",      bus.instret, 32'd8);
        step(I_ADD, 1'b0);
        check("c12_squash_write", 32'(bus.ctrl[1]), 32'h0);
        check("c12_instret",      bus.instret, 32'd8);
        step(I_ADD, 1'b0);
        check("c13_target_write", 32'(bus.ctrl[1]), 32'h1);

        // Not-taken beq, then taken bne with illegal words in its squash window
        step(I_BEQ, 1'b0);
        check("c14_instret",     bus.instret, 32'd9);
        step(I_ADD, 1'b0);
        check("c15_beq_not_taken", 32'(bus.ctrl[0]), 32'h0);
        step(I_ADD, 1'b0);
        check("c16_beq_nowrite", 32'(bus.ctrl[1]), 32'h0);
        step(I_BNE, 1'b0);
        check("c17_add_after_nt", 32'(bus.ctrl[1]), 32'h1);
        step(I_BAD, 1'b0);
        check("c18_bne_taken",   32'(bus.ctrl[0]), 32'h1);
        step(I_BAD, 1'b0);
        check("c19_ex_bubble",   32'(bus.ctrl[0]), 32'h0);
        step(I_ADD, 1'b0);
        check("c20_squashed_illegal", 32'(bus.illegal), 32'h0);
        step(I_BAD, 1'b0);
        check("c21_illegal_pre", 32'(bus.illegal), 32'h0);
        step(I_ADD, 1'b0);
        check("c22_illegal_set", 32'(bus.illegal), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(I_ADD, 1'b0);
            check("illegal_sticky", 32'(bus.illegal), 32'h1);
        end

        // Reset while a sw sits in EX
        step(I_SW, 1'b0);
        step(I_ADD, 1'b0);
        check("sw_in_ex_alusrc", 32'(bus.ctrl[6]), 32'h1);
        rst = 1'b1;
        step(I_ADD, 1'b0);
        rst = 1'b0;
        check("post_rst_memwrite", 32'(bus.ctrl[11]), 32'h0);
        check("post_rst_regwrite", 32'(bus.ctrl[1]), 32'h0);
        check("post_rst_instret",  bus.instret, 32'd0);
        check("post_rst_illegal",  32'(bus.illegal), 32'h0);
        step(I_ADD, 1'b0);
        check("post_rst_memwrite2", 32'(bus.ctrl[11]), 32'h0);
        check("post_rst_add_ex",    32'(bus.ctrl[7:10]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_ctrl_pipe.md
# rv32_ctrl_pipe

Pipelined control unit for the three-stage RV32 core. It decodes the fetched instruction word and produces the 13-bit control word `ctrl[0:12]` that steers the datapath. Each field is timed to the stage that consumes it: decode, execute, or memory/writeback. It also squashes wrong-path instructions after a taken branch, flags illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32, instruction and counter width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `inst`  in  32  instruction from synchronous imem; valid in the decode (D) cycle.
- `alu_zero`  in  1  ALU result == 0; combinational from the execute (EX) stage in the same cycle.
- `ctrl`  out  13 `[0:12]`  datapath control word (fields below).
- `illegal`  out  1  sticky: an unsupported opcode was decoded.
- `instret`  out  XLEN  count of retired non-bubble instructions.

## Operation
Control word fields:
- `ctrl[0]`: pc select; 1 = branch target.
- `ctrl[1]`: register write.
- `ctrl[2:3]`: reserved, always 0.
- `ctrl[4:5]`: immediate format. 00 = I, 01 = S, 10 = B, 11 = unused.
- `ctrl[6]`: ALU operand B select; 1 = immediate.
- `ctrl[7:10]`: ALU op.
- `ctrl[11]`: dmem write.
- `ctrl[12]`: writeback select; 1 = dmem data.

Decode of `inst[6:0]`:
- 0110011 R: aluop = `{inst[30], funct3}`, regwrite = 1.
- 0010011 I-ALU: aluop = `{inst[30] & (funct3==101), funct3}`, alusrc = 1, regwrite = 1.
- 0000011 LOAD: aluop 0000, alusrc = 1, regwrite = 1, mem2reg = 1. Only funct3 = 010 is legal.
- 0100011 STORE: imm = S, aluop 0000, alusrc = 1, memwrite = 1. Only funct3 = 010 is legal.
- 1100011 BRANCH: imm = B, aluop 1000 (sub), branch = 1. funct3 000 = beq, 001 = bne; any other funct3 is illegal.
- Any other opcode: illegal; the instruction becomes a bubble (all fields 0).

Pipeline registers:
- EX register holds `{valid, branch, bne, alusrc, aluop, regwrite, memwrite, mem2reg}`.
- MW register holds `{valid, regwrite, memwrite, mem2reg}`.

Stage sourcing of `ctrl`:
- `ctrl[4:5]` comes combinationally from `inst` (D stage).
- `ctrl[6:10]` comes from the EX register.
- `ctrl[1]`, `ctrl[11:12]` come from the MW register.
- `ctrl[0]` = EX.branch & (EX.bne ? ~alu_zero : alu_zero), combinational.

Branch squash:
- When `ctrl[0]`=1, a 2-bit squash counter loads 2.
- While the counter is nonzero, the D instruction is loaded into EX as a bubble and the counter decrements.
- A branch never carries write fields into MW.

Illegal flag:
- `illegal` sets when an illegal opcode decodes outside a squash window.
- It clears only on `rst`.
- A squashed illegal word does not set it.

Retire counter:
- `instret` increments when MW.valid = 1.
- It wraps from 2^XLEN−1 to 0.

## Timing
- Reset: EX, MW, the squash counter, `illegal`, and `instret` are all 0. `ctrl` = 0 except `ctrl[4:5]`, which follows `inst`.
- Latency: an instruction presented in D at cycle n drives its EX fields in cycle n+1 and its MW fields in cycle n+2. It is counted in `instret` at the edge ending n+2.
- Taken branch in EX at cycle t: the D words at t and t+1 become bubbles; the first target instruction enters EX at t+3.
- Branch in EX while the squash counter is nonzero: cannot occur, because EX holds a bubble.
- `rst` asserted mid-operation clears every stage on that edge. No partial write survives: `ctrl[1]` and `ctrl[11]` are 0 in the cycle after the reset edge.
- No stalls: the pipeline advances every cycle.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`);
  - immediate format codes;
  - ALU op encodings;
  - control-bit index constants for `ctrl`.
- One sub-module `rv32_decode`: purely combinational opcode/funct to control-fields decode plus the illegal indication. The pipeline registers, squash counter, and retire counter stay in `rv32_ctrl_pipe`.

## Test plan
- R-type `add x3,x1,x2` (0x002081B3) in D at cycle 1 -> cycle 2: `ctrl[6]`=0, `ctrl[7:10]`=0000. Cycle 3: `ctrl[1]`=1, `ctrl[12]`=0. `instret`=1 after cycle 3.
- `sw x2,4(x1)` (0x0020A223) -> `ctrl[4:5]`=01 in D; cycle +1: `ctrl[6]`=1; cycle +2: `ctrl[11]`=1, `ctrl[1]`=0.
- `beq` (0x00208463) with `alu_zero`=1 in EX -> `ctrl[0]`=1; the next two D words (e.g. 0x002081B3 twice) never raise `ctrl[1]`; `instret` advances by exactly 1 for the branch.
- Same `beq` with `alu_zero`=0 -> `ctrl[0]`=0; the following `add` reaches MW with `ctrl[1]`=1.
- Opcode 0x0000007F in D -> `illegal`=1 next cycle, stays 1 through 10 further legal instructions, and clears on `rst`. The same word inside a squash window leaves `illegal`=0.
- `rst` pulsed while a `sw` is in EX -> `ctrl[11]` never asserts for it; `instret`=0 after reset.
